// File: rtl/stream_rr_arbiter_pkg.sv
// Shared helpers for the stream round-robin arbiter and its selector.
// No ports; provides index-width derivation used for tags, ptr and grant.
package stream_rr_arbiter_pkg;

    // Bits needed to index n sources, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Stream interfaces shared by the arbiter and its neighbours.
// data_i   : data, keep, last, valid forward; ready backward.
// tagged_i : as data_i plus a source-index tag.
interface data_i #(
    parameter type data_t = logic [31:0]
);
    localparam int unsigned KEEP_W = ($bits(data_t) + 7) / 8;

    data_t             data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              valid;
    logic              ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

interface tagged_i #(
    parameter type         data_t    = logic [31:0],
    parameter int unsigned TAG_WIDTH = 2
);
    localparam int unsigned KEEP_W = ($bits(data_t) + 7) / 8;

    data_t                data;
    logic [TAG_WIDTH-1:0] tag;
    logic [KEEP_W-1:0]    keep;
    logic                 last;
    logic                 valid;
    logic                 ready;

    modport m (output data, tag, keep, last, valid, input ready);
    modport s (input data, tag, keep, last, valid, output ready);
endinterface

// File: rtl/stream_rr_arbiter_rr_select.sv
// Wrap-around first-set search: finds the first set bit of req starting at
// ptr and wrapping from N-1 to 0. Purely combinational.
// req   : request vector
// ptr   : search start index (must be < N)
// found : at least one request set
// index : winning request index (0 when none found)
module rr_select #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    always_comb begin
        int unsigned cand;
        found = 1'b0;
        index = '0;
        cand  = 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin merge of NUM_INPUTS streams into one tagged stream.
// A packet owner holds the output until its last beat; the search pointer
// moves past the source only when a packet completes.
// clk, rst : clock, asynchronous active-high reset
// in[]     : request streams (sink side), ready driven only to the selected one
// out      : registered merged stream with source tag, 1-cycle latency
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter type         data_t     = logic [31:0],
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned TAG_WIDTH  = idx_width(NUM_INPUTS)
) (
    input logic clk,
    input logic rst,
    data_i.s    in [NUM_INPUTS],
    tagged_i.m  out
);

    localparam int unsigned IW     = idx_width(NUM_INPUTS);
    localparam int unsigned KEEP_W = ($bits(data_t) + 7) / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic [NUM_INPUTS-1:0] vld;
    logic [NUM_INPUTS-1:0] lst;
    logic [NUM_INPUTS-1:0] rdy_c;
    data_t                 dat [NUM_INPUTS];
    logic [KEEP_W-1:0]     kp  [NUM_INPUTS];

    // Flatten the interface array so the selector can index it.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_flat
        assign vld[i]      = in[i].valid;
        assign lst[i]      = in[i].last;
        assign dat[i]      = in[i].data;
        assign kp[i]       = in[i].keep;
        assign in[i].ready = rdy_c[i];
    end

    state_t               state_q, state_n;
    logic [IW-1:0]        ptr_q, ptr_n;
    logic [IW-1:0]        g_q, g_n;
    logic                 ov_q, ov_n;
    data_t                od_q, od_n;
    logic [TAG_WIDTH-1:0] ot_q, ot_n;
    logic [KEEP_W-1:0]    ok_q, ok_n;
    logic                 ol_q, ol_n;

    logic                 win_found_c;
    logic [IW-1:0]        win_idx_c;
    logic [IW-1:0]        sel_c;
    logic                 sel_ok_c;
    logic                 can_load_c;
    logic                 acc_c;

    rr_select #(
        .N  (NUM_INPUTS),
        .IW (IW)
    ) u_rr_select (
        .req   (vld),
        .ptr   (ptr_q),
        .found (win_found_c),
        .index (win_idx_c)
    );

    // State, pointer, grant and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ot_q    <= '0;
            ok_q    <= '0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            g_q     <= g_n;
            ov_q    <= ov_n;
            od_q    <= od_n;
            ot_q    <= ot_n;
            ok_q    <= ok_n;
            ol_q    <= ol_n;
        end
    end

    // Selection, ready steering, accept and next-state.
    always_comb begin
        state_n    = state_q;
        ptr_n      = ptr_q;
        g_n        = g_q;
        ov_n       = ov_q;
        od_n       = od_q;
        ot_n       = ot_q;
        ok_n       = ok_q;
        ol_n       = ol_q;
        rdy_c      = '0;

        // IDLE picks fresh every cycle, so a stalled output commits nothing.
        sel_c      = (state_q == LOCKED) ? g_q : win_idx_c;
        sel_ok_c   = (state_q == LOCKED) || win_found_c;
        can_load_c = !ov_q || out.ready;
        acc_c      = 1'b0;

        if (!rst && sel_ok_c) begin
            rdy_c[sel_c] = can_load_c;
            acc_c        = can_load_c && vld[sel_c];
        end

        if (acc_c) begin
            ov_n = 1'b1;
            od_n = dat[sel_c];
            ok_n = kp[sel_c];
            ol_n = lst[sel_c];
            ot_n = TAG_WIDTH'(sel_c);
            if (lst[sel_c]) begin
                state_n = IDLE;
                ptr_n   = (sel_c == IW'(NUM_INPUTS - 1)) ? '0 : sel_c + IW'(1);
            end else if (state_q == IDLE) begin
                state_n = LOCKED;
                g_n     = sel_c;
            end
        end else if (ov_q && out.ready) begin
            ov_n = 1'b0;
        end
    end

    assign out.valid = ov_q;
    assign out.data  = od_q;
    assign out.tag   = ot_q;
    assign out.keep  = ok_q;
    assign out.last  = ol_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed table + hand sequences + randomized scoreboard for stream_rr_arbiter.
`timescale 1ns/1ps
module tb_stream_rr_arbiter;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic [N-1:0] rdy;
    logic [31:0]  d [N];
    logic         ord;

    logic         v1s, l1s, rdy1;
    logic [31:0]  d1s;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] keep_of(input int unsigned i);
        return 4'((i * 5) ^ 10);
    endfunction

    data_i   #(.data_t(logic [31:0]))                 din [N] ();
    tagged_i #(.data_t(logic [31:0]), .TAG_WIDTH(2))  dout ();

    for (genvar i = 0; i < N; i++) begin : g_src
        assign din[i].valid = v[i];
        assign din[i].data  = d[i];
        assign din[i].keep  = keep_of(i);
        assign din[i].last  = l[i];
        assign rdy[i]       = din[i].ready;
    end
    assign dout.ready = ord;

    stream_rr_arbiter #(
        .data_t     (logic [31:0]),
        .NUM_INPUTS (N),
        .TAG_WIDTH  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    data_i   #(.data_t(logic [31:0]))                 din1 [1] ();
    tagged_i #(.data_t(logic [31:0]), .TAG_WIDTH(1))  dout1 ();

    assign din1[0].valid = v1s;
    assign din1[0].data  = d1s;
    assign din1[0].keep  = 4'h9;
    assign din1[0].last  = l1s;
    assign rdy1          = din1[0].ready;
    assign dout1.ready   = 1'b1;

    stream_rr_arbiter #(
        .data_t     (logic [31:0]),
        .NUM_INPUTS (1),
        .TAG_WIDTH  (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .in  (din1),
        .out (dout1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [3:0] vm, input logic [3:0] lm, input logic o);
        v   = vm;
        l   = lm;
        ord = o;
    endtask

    // Check one cycle at the negedge, then advance to just after the next posedge.
    task automatic cyc(input string nm, input logic [3:0] er, input logic eov,
                       input logic [1:0] et, input logic [31:0] ed, input logic el);
        @(negedge clk);
        chk({nm, ".ready"}, 64'(rdy), 64'(er));
        chk({nm, ".valid"}, 64'(dout.valid), 64'(eov));
        if (eov) begin
            chk({nm, ".tag"},  64'(dout.tag),  64'(et));
            chk({nm, ".data"}, 64'(dout.data), 64'(ed));
            chk({nm, ".last"}, 64'(dout.last), 64'(el));
            chk({nm, ".keep"}, 64'(dout.keep), 64'(keep_of(32'(et))));
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0]  vm;
        logic        o;
        logic [3:0]  er;
        logic        eov;
        logic [1:0]  et;
        logic [31:0] ed;
    } vec_t;

    vec_t        tbl [17];
    int unsigned seq [N];
    logic        cl [N];
    logic [32:0] expq [N][$];
    logic [32:0] e;
    logic        lock_on;
    logic [1:0]  lock_tag;
    logic [1:0]  t;

    initial begin
        // Single-beat packets; source i in row r carries data r*16+i.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h00};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h00};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h11};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h22};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h33};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h40};
        tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h51};
        tbl[7]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h62};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h73};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h80};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00};
        tbl[11] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 32'h00};
        tbl[12] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hB1};
        tbl[13] = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hB1};
        tbl[14] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd1, 32'hB1};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'hE2};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00};

        rst = 1'b1;
        drv(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < N; i++) d[i] = 32'h0;
        v1s = 1'b0; l1s = 1'b1; d1s = 32'h0;

        // Reset state with every input requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 64'(rdy), 64'h0);
        chk("rst.valid", 64'(dout.valid), 64'h0);
        chk("rst.tag",   64'(dout.tag), 64'h0);
        chk("rst.data",  64'(dout.data), 64'h0);
        chk("rst.keep",  64'(dout.keep), 64'h0);
        chk("rst.last",  64'(dout.last), 64'h0);
        chk("rst.n1valid", 64'(dout1.valid), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin, wrap, idle/no-request and stalled-IDLE rearbitration.
        for (int r = 0; r < 17; r++) begin
            drv(tbl[r].vm, 4'b1111, tbl[r].o);
            for (int i = 0; i < N; i++) d[i] = 32'(r * 16 + i);
            cyc($sformatf("tbl%0d", r), tbl[r].er, tbl[r].eov, tbl[r].et, tbl[r].ed, 1'b1);
        end

        // Input 2 three-beat packet while input 0 waits (ptr=3).
        d[2] = 32'hA; drv(4'b0100, 4'b0000, 1'b1);
        cyc("s2a", 4'b0100, 1'b0, 2'd0, 32'h0, 1'b0);
        d[2] = 32'hB; d[0] = 32'hD; drv(4'b0101, 4'b0001, 1'b1);
        cyc("s2b", 4'b0100, 1'b1, 2'd2, 32'hA, 1'b0);
        d[2] = 32'hC; drv(4'b0101, 4'b0101, 1'b1);
        cyc("s2c", 4'b0100, 1'b1, 2'd2, 32'hB, 1'b0);
        drv(4'b0001, 4'b0001, 1'b1);
        cyc("s2d", 4'b0001, 1'b1, 2'd2, 32'hC, 1'b1);
        drv(4'b0000, 4'b0000, 1'b1);
        cyc("s2e", 4'b0000, 1'b1, 2'd0, 32'hD, 1'b1);

        // Output stall of 5 cycles mid-packet on input 1.
        d[1] = 32'h31; drv(4'b0010, 4'b0000, 1'b1);
        cyc("s3a", 4'b0010, 1'b0, 2'd0, 32'h0, 1'b0);
        d[1] = 32'h32; drv(4'b0010, 4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) cyc("s3stall", 4'b0000, 1'b1, 2'd1, 32'h31, 1'b0);
        drv(4'b0010, 4'b0000, 1'b1);
        cyc("s3b", 4'b0010, 1'b1, 2'd1, 32'h31, 1'b0);
        d[1] = 32'h33; drv(4'b0010, 4'b0010, 1'b1);
        cyc("s3c", 4'b0010, 1'b1, 2'd1, 32'h32, 1'b0);
        drv(4'b0000, 4'b0000, 1'b1);
        cyc("s3d", 4'b0000, 1'b1, 2'd1, 32'h33, 1'b1);
        cyc("s3e", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0);

        // Owner 1 drops valid for 4 cycles while input 3 waits.
        d[1] = 32'h41; drv(4'b0010, 4'b0000, 1'b1);
        cyc("s4a", 4'b0010, 1'b0, 2'd0, 32'h0, 1'b0);
        d[3] = 32'h4F; drv(4'b1000, 4'b1000, 1'b1);
        cyc("s4drop", 4'b0010, 1'b1, 2'd1, 32'h41, 1'b0);
        for (int k = 0; k < 3; k++) cyc("s4drop", 4'b0010, 1'b0, 2'd0, 32'h0, 1'b0);
        d[1] = 32'h42; drv(4'b1010, 4'b1010, 1'b1);
        cyc("s4b", 4'b0010, 1'b0, 2'd0, 32'h0, 1'b0);
        drv(4'b1000, 4'b1000, 1'b1);
        cyc("s4c", 4'b1000, 1'b1, 2'd1, 32'h42, 1'b1);
        drv(4'b0000, 4'b0000, 1'b1);
        cyc("s4d", 4'b0000, 1'b1, 2'd3, 32'h4F, 1'b1);
        cyc("s4e", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0);

        // Asynchronous reset mid-packet on input 3.
        d[3] = 32'h51; drv(4'b1000, 4'b0000, 1'b1);
        cyc("s5a", 4'b1000, 1'b0, 2'd0, 32'h0, 1'b0);
        d[3] = 32'h52;
        cyc("s5b", 4'b1000, 1'b1, 2'd3, 32'h51, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("s5rst.valid", 64'(dout.valid), 64'h0);
        chk("s5rst.ready", 64'(rdy), 64'h0);
        chk("s5rst.data",  64'(dout.data), 64'h0);
        d[0] = 32'h60; d[3] = 32'h63; drv(4'b1001, 4'b1001, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("s5c", 4'b0001, 1'b0, 2'd0, 32'h0, 1'b0);
        drv(4'b1000, 4'b1000, 1'b1);
        cyc("s5d", 4'b1000, 1'b1, 2'd0, 32'h60, 1'b1);
        drv(4'b0000, 4'b0000, 1'b1);
        cyc("s5e", 4'b0000, 1'b1, 2'd3, 32'h63, 1'b1);

        // Single-input instance: pass-through with tag 0.
        v1s = 1'b1; d1s = 32'hAB; l1s = 1'b1;
        @(negedge clk);
        chk("n1.ready", 64'(rdy1), 64'h1);
        chk("n1.valid0", 64'(dout1.valid), 64'h0);
        @(posedge clk);
        #1;
        v1s = 1'b0;
        @(negedge clk);
        chk("n1.valid1", 64'(dout1.valid), 64'h1);
        chk("n1.data", 64'(dout1.data), 64'hAB);
        chk("n1.tag", 64'(dout1.tag), 64'h0);
        chk("n1.keep", 64'(dout1.keep), 64'h9);
        @(posedge clk);
        #1;

        // Random traffic against a per-source ordered scoreboard.
        lock_on  = 1'b0;
        lock_tag = 2'd0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            cl[i]  = ($urandom_range(0, 2) == 0);
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                d[i] = {8'(i), 24'(seq[i])};
                l[i] = cl[i];
                v[i] = ($urandom_range(0, 9) < 7);
            end
            ord = ($urandom_range(0, 3) != 0);
            if (c >= 360) begin
                v   = '0;
                ord = 1'b1;
            end
            @(negedge clk);
            chk("rnd.onehot", 64'($onehot0(rdy)), 64'h1);
            if (dout.valid && ord) begin
                t = dout.tag;
                if (lock_on) chk("rnd.contig", 64'(t), 64'(lock_tag));
                chk("rnd.qsize", 64'(expq[t].size() != 0), 64'h1);
                if (expq[t].size() != 0) begin
                    e = expq[t].pop_front();
                    chk("rnd.beat", 64'({dout.last, dout.data}), 64'(e));
                end
                lock_on  = !dout.last;
                lock_tag = t;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && rdy[i]) begin
                    expq[i].push_back({l[i], d[i]});
                    seq[i] = seq[i] + 1;
                    cl[i]  = ($urandom_range(0, 2) == 0);
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < N; i++) chk("rnd.drain", 64'(expq[i].size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
